bk_audio_decim: RTL and testbench



---
 rtl/bk_audio_decim.sv | 104 ++++++++++
 tb/tb_bk_audio_decim.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/bk_audio_decim.sv
// PSG/speaker audio mixer with box-car decimation to registered 16-bit samples.
// Optional one-pole IIR smoothing after the decimator: define BK_AUDIO_LPF_EN.
module bk_audio_decim #(
  parameter int unsigned DECIM_LOG2 = 5,
  parameter int unsigned LPF_SHIFT  = 2
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        ce_psg,
  input  logic [7:0]  channel_a,
  input  logic [7:0]  channel_b,
  input  logic [7:0]  channel_c,
  input  logic [5:0]  psg_active,
  input  logic [2:0]  spk_out,
  output logic [15:0] audio_l,
  output logic [15:0] audio_r,
  output logic        sample_stb
);

  localparam int unsigned ACC_W = 10 + DECIM_LOG2;

  logic [9:0]            w_raw_l;
  logic [9:0]            w_raw_r;
  logic [ACC_W-1:0]      w_sum_l;
  logic [ACC_W-1:0]      w_sum_r;
  logic [15:0]           w_x_l;
  logic [15:0]           w_x_r;
  logic                  w_wrap;

  logic [DECIM_LOG2-1:0] r_cnt;
  logic [ACC_W-1:0]      r_acc_l;
  logic [ACC_W-1:0]      r_acc_r;
  logic [15:0]           r_audio_l;
  logic [15:0]           r_audio_r;
  logic                  r_stb;

  always_comb begin
    w_raw_l = '0;
    w_raw_r = '0;
    if (psg_active != '0) begin
      w_raw_l = {1'b0, channel_a, 1'b0} + {2'b0, channel_b} + {2'b0, spk_out, 5'b0};
      w_raw_r = {1'b0, channel_c, 1'b0} + {2'b0, channel_b} + {2'b0, spk_out, 5'b0};
    end else begin
      w_raw_l = {spk_out, 7'b0};
      w_raw_r = {spk_out, 7'b0};
    end
  end

  // Top 10 bits of the full-window sum are the truncated average.
  assign w_sum_l = r_acc_l + {{DECIM_LOG2{1'b0}}, w_raw_l};
  assign w_sum_r = r_acc_r + {{DECIM_LOG2{1'b0}}, w_raw_r};
  assign w_x_l   = {w_sum_l[ACC_W-1 -: 10], 6'b0};
  assign w_x_r   = {w_sum_r[ACC_W-1 -: 10], 6'b0};
  assign w_wrap  = ce_psg && (r_cnt == '1);

`ifdef BK_AUDIO_LPF_EN
  // y += (x - y) >>> LPF_SHIFT in 17-bit signed; floor shift keeps y within 0..x_max.
  function automatic logic [15:0] lpf_step(input logic [15:0] y, input logic [15:0] x);
    logic signed [16:0] d;
    logic signed [16:0] s;
    d = $signed({1'b0, x}) - $signed({1'b0, y});
    d = d >>> LPF_SHIFT;
    s = $signed({1'b0, y}) + d;
    return s[15:0];
  endfunction
`endif

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt     <= '0;
      r_acc_l   <= '0;
      r_acc_r   <= '0;
      r_audio_l <= '0;
      r_audio_r <= '0;
      r_stb     <= 1'b0;
    end else begin
      r_stb <= 1'b0;
      if (ce_psg) begin
        r_cnt <= r_cnt + 1'b1;
        if (w_wrap) begin
          r_acc_l <= '0;
          r_acc_r <= '0;
          r_stb   <= 1'b1;
`ifdef BK_AUDIO_LPF_EN
          // The output register doubles as the filter state y.
          r_audio_l <= lpf_step(r_audio_l, w_x_l);
          r_audio_r <= lpf_step(r_audio_r, w_x_r);
`else
          r_audio_l <= w_x_l;
          r_audio_r <= w_x_r;
`endif
        end else begin
          r_acc_l <= w_sum_l;
          r_acc_r <= w_sum_r;
        end
      end
    end
  end

  assign audio_l    = r_audio_l;
  assign audio_r    = r_audio_r;
  assign sample_stb = r_stb;

endmodule

// File: tb/tb_bk_audio_decim.sv
// Scoreboard bench for bk_audio_decim: stimulus pushes expected samples, monitor pops on sample_stb.
module tb_bk_audio_decim;

  logic        clk_sys = 1'b0;
  logic        reset_n;
  logic        ce_psg;
  logic [7:0]  channel_a, channel_b, channel_c;
  logic [5:0]  psg_active;
  logic [2:0]  spk_out;
  logic [15:0] audio_l, audio_r;
  logic        sample_stb;

  always #5 clk_sys = ~clk_sys;

  bk_audio_decim dut (
    .clk_sys    (clk_sys),
    .reset_n    (reset_n),
    .ce_psg     (ce_psg),
    .channel_a  (channel_a),
    .channel_b  (channel_b),
    .channel_c  (channel_c),
    .psg_active (psg_active),
    .spk_out    (spk_out),
    .audio_l    (audio_l),
    .audio_r    (audio_r),
    .sample_stb (sample_stb)
  );

  typedef struct {
    logic [15:0] l;
    logic [15:0] r;
    int unsigned c;
  } exp_t;

  exp_t        q[$];
  int unsigned cyc = 0;
  int unsigned n_chk = 0;
  int unsigned n_fail = 0;
  logic [15:0] last_l = '0, last_r = '0;
  int unsigned last_stb_cyc = 0;
  bit          have_last = 1'b0;
  bit          chk_spacing = 1'b0;
  logic [15:0] y_l = '0, y_r = '0;

  always @(posedge clk_sys) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference IIR written as floor division of the signed difference.
  function automatic logic [15:0] lpf_ref(input logic [15:0] y, input logic [15:0] x);
    int d, q4;
    d = int'(x) - int'(y);
    if (d >= 0) q4 = d / 4;
    else        q4 = -((-d + 3) / 4);
    return 16'(int'(y) + q4);
  endfunction

  task automatic push_exp(input logic [15:0] xl, input logic [15:0] xr);
    exp_t e;
`ifdef BK_AUDIO_LPF_EN
    y_l = lpf_ref(y_l, xl);
    y_r = lpf_ref(y_r, xr);
    e.l = y_l;
    e.r = y_r;
`else
    e.l = xl;
    e.r = xr;
`endif
    e.c = cyc + 1;
    q.push_back(e);
  endtask

  always @(negedge clk_sys) begin
    if (reset_n === 1'b1 && sample_stb === 1'b1) begin
      if (q.size() == 0) begin
        chk("unexpected_stb", 32'(cyc), 32'hFFFF_FFFF);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("sample_lr", {audio_l, audio_r}, {e.l, e.r});
        chk("stb_cycle", 32'(cyc), 32'(e.c));
      end
      if (chk_spacing && have_last)
        chk("stb_spacing", 32'(cyc - last_stb_cyc), 32'd1792);
      last_stb_cyc = cyc;
      have_last    = 1'b1;
      last_l       = audio_l;
      last_r       = audio_r;
    end
  end

  // One ce_psg pulse; with gap>=2 the inputs are scrambled while ce_psg is low.
  task automatic pulse(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                       input logic [5:0] pa, input logic [2:0] s, input int unsigned gap,
                       input bit do_push, input logic [15:0] xl, input logic [15:0] xr);
    @(negedge clk_sys);
    channel_a = a; channel_b = b; channel_c = c; psg_active = pa; spk_out = s;
    ce_psg = 1'b1;
    if (do_push) push_exp(xl, xr);
    if (gap >= 2) begin
      @(negedge clk_sys);
      ce_psg = 1'b0;
      channel_a = 8'($urandom); channel_b = 8'($urandom); channel_c = 8'($urandom);
      psg_active = 6'($urandom); spk_out = 3'($urandom);
      repeat (gap - 2) @(negedge clk_sys);
    end
  endtask

  task automatic window(input int unsigned n, input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] c, input logic [5:0] pa, input logic [2:0] s,
                        input int unsigned gap, input bit push_last,
                        input logic [15:0] xl, input logic [15:0] xr);
    for (int unsigned i = 0; i < n; i++)
      pulse(a, b, c, pa, s, gap, push_last && (i == n - 1), xl, xr);
  endtask

  task automatic drain();
    @(negedge clk_sys);
    ce_psg = 1'b0;
    for (int i = 0; i < 300 && q.size() > 0; i++) @(negedge clk_sys);
    chk("drain_pending", 32'(q.size()), 32'd0);
  endtask

  task automatic do_reset(input bit check_now);
    @(negedge clk_sys);
    reset_n = 1'b0;
    #1;
    if (check_now) begin
      chk("rst_audio_l", 32'(audio_l), 32'd0);
      chk("rst_audio_r", 32'(audio_r), 32'd0);
      chk("rst_stb", 32'(sample_stb), 32'd0);
    end
    y_l = '0;
    y_r = '0;
    have_last = 1'b0;
    repeat (2) @(negedge clk_sys);
    reset_n = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
    n_fail++;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0; ce_psg = 1'b0;
    channel_a = '0; channel_b = '0; channel_c = '0; psg_active = '0; spk_out = '0;
    repeat (3) @(negedge clk_sys);
    chk("reset_audio_l", 32'(audio_l), 32'd0);
    chk("reset_audio_r", 32'(audio_r), 32'd0);
    chk("reset_stb", 32'(sample_stb), 32'd0);
    reset_n = 1'b1;

    // Speaker only: 7*128 = 896 -> 0xE000
    window(32, 8'h00, 8'h00, 8'h00, 6'h00, 3'b111, 56, 1'b1, 16'hE000, 16'hE000);
    drain();

    // PSG mix: L = 256+64 = 320 -> 0x5000, R = 32+64 = 96 -> 0x1800
    window(32, 8'h80, 8'h40, 8'h10, 6'h01, 3'b000, 56, 1'b1, 16'h5000, 16'h1800);
    drain();

    // Truncation: 31*128/32 = 124 -> 0x1F00
    window(31, 8'h00, 8'h00, 8'h00, 6'h00, 3'b001, 56, 1'b0, 16'h0, 16'h0);
    window(1,  8'h00, 8'h00, 8'h00, 6'h00, 3'b000, 56, 1'b1, 16'h1F00, 16'h1F00);
    drain();

    // Per-sample psg_active: L avg (16*128+16*256)/32 = 192, R (0+16*256)/32 = 128
    window(16, 8'h40, 8'h00, 8'h00, 6'h20, 3'b000, 56, 1'b0, 16'h0, 16'h0);
    window(16, 8'hFF, 8'hFF, 8'hFF, 6'h00, 3'b010, 56, 1'b1, 16'h3000, 16'h2000);
    drain();

    // Consecutive enables, worst-case mix 989 -> 0xF740
    window(32, 8'hFF, 8'hFF, 8'hFF, 6'h3F, 3'b111, 1, 1'b1, 16'hF740, 16'hF740);
    drain();

    // Mid-window reset, then two back-to-back windows with spacing check
    window(20, 8'h00, 8'h00, 8'h00, 6'h00, 3'b111, 56, 1'b0, 16'h0, 16'h0);
    do_reset(1'b1);
    window(32, 8'h00, 8'h00, 8'h00, 6'h00, 3'b001, 56, 1'b1, 16'h2000, 16'h2000);
    chk_spacing = 1'b1;
    window(32, 8'h00, 8'h00, 8'h00, 6'h00, 3'b111, 56, 1'b1, 16'hE000, 16'hE000);
    drain();
    chk_spacing = 1'b0;

`ifdef BK_AUDIO_LPF_EN
    do_reset(1'b1);
    window(32, 8'h00, 8'h00, 8'h00, 6'h00, 3'b111, 56, 1'b1, 16'hE000, 16'hE000);
    drain();
    chk("lpf_step1", 32'(last_l), 32'h3800);
    window(32, 8'h00, 8'h00, 8'h00, 6'h00, 3'b111, 56, 1'b1, 16'hE000, 16'hE000);
    drain();
    chk("lpf_step2", 32'(last_l), 32'h6200);
    window(32, 8'h00, 8'h00, 8'h00, 6'h00, 3'b111, 56, 1'b1, 16'hE000, 16'hE000);
    drain();
    chk("lpf_step3", 32'(last_l), 32'h8180);
    for (int k = 0; k < 4; k++) begin
      logic [15:0] prev;
      prev = last_l;
      window(32, 8'h00, 8'h00, 8'h00, 6'h00, 3'b111, 56, 1'b1, 16'hE000, 16'hE000);
      drain();
      chk("lpf_monotonic", 32'(last_l >= prev), 32'd1);
      chk("lpf_no_overshoot", 32'(last_l <= 16'hE000), 32'd1);
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
